// File: rtl/vlsu_pkg.sv
// Shared types for the VLSU memory-ordering scheduler.
package vlsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        DISPATCH = 2'd2
    } order_state_e;

    function automatic int unsigned outstanding_cnt_w(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/vlsu_outstanding_cnt.sv
// Saturating up/down counter of in-flight AXI transactions with a sticky
// under/overflow flag.
module vlsu_outstanding_cnt
    import vlsu_pkg::*;
#(
    parameter int unsigned Max  = 8,
    localparam int unsigned CntW = outstanding_cnt_w(Max)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            err_o
);

    logic [CntW-1:0] cnt_q;
    logic            err_q;
    logic            full;
    logic            empty;

    assign full  = (cnt_q == CntW'(Max));
    assign empty = (cnt_q == '0);

    // Simultaneous inc and dec cancel, so they never flag an error even at a bound.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (inc_i && !dec_i) begin
            if (full) err_q <= 1'b1;
            else      cnt_q <= cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (empty) err_q <= 1'b1;
            else       cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = full;
    assign err_o  = err_q;

endmodule

// File: rtl/vlsu_mem_order_ctrl.sv
// Holds one vector load/store request and releases it to the ControlMachine
// only once no load/store ordering hazard remains; also caps AR/AW issue.
module vlsu_mem_order_ctrl
    import vlsu_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 8,
    parameter type         req_t          = logic,
    localparam int unsigned CntW          = outstanding_cnt_w(MaxOutstanding)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  req_t            req_i,
    input  logic            req_is_load_i,
    input  logic            core_st_pending_i,
    output logic            cm_req_valid_o,
    input  logic            cm_req_ready_i,
    output req_t            cm_req_o,
    input  logic            cm_idle_i,
    input  logic            ar_hs_i,
    input  logic            r_last_hs_i,
    input  logic            aw_hs_i,
    input  logic            b_hs_i,
    output logic            ar_allow_o,
    output logic            aw_allow_o,
    output logic [CntW-1:0] ld_cnt_o,
    output logic [CntW-1:0] st_cnt_o,
    output logic            err_o
);

    order_state_e    state_q;
    req_t            req_q;
    logic            is_load_q;
    logic            dir_is_load_q;
    logic            req_ready_q;
    logic            cm_valid_q;
    logic            hazard;
    logic [CntW-1:0] ld_cnt;
    logic [CntW-1:0] st_cnt;
    logic            ld_full;
    logic            st_full;
    logic            ld_err;
    logic            st_err;

    vlsu_outstanding_cnt #(.Max(MaxOutstanding)) i_ld_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (ar_hs_i),
        .dec_i  (r_last_hs_i),
        .cnt_o  (ld_cnt),
        .full_o (ld_full),
        .err_o  (ld_err)
    );

    vlsu_outstanding_cnt #(.Max(MaxOutstanding)) i_st_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (aw_hs_i),
        .dec_i  (b_hs_i),
        .cnt_o  (st_cnt),
        .full_o (st_full),
        .err_o  (st_err)
    );

    // A load waits for every older store (vector or scalar core); a store waits
    // for load data. The previous request's direction matters only while the
    // ControlMachine is still issuing its address beats.
    always_comb begin
        hazard = 1'b0;
        if (is_load_q) begin
            hazard = (st_cnt != '0) || core_st_pending_i || (!dir_is_load_q && !cm_idle_i);
        end else begin
            hazard = (ld_cnt != '0) || (dir_is_load_q && !cm_idle_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            req_q         <= '0;
            is_load_q     <= 1'b0;
            dir_is_load_q <= 1'b1;
            req_ready_q   <= 1'b1;
            cm_valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q       <= req_i;
                        is_load_q   <= req_is_load_i;
                        req_ready_q <= 1'b0;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!hazard) begin
                        cm_valid_q <= 1'b1;
                        state_q    <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    // Once offered, the request stays offered regardless of new hazards.
                    if (cm_req_ready_i) begin
                        dir_is_load_q <= is_load_q;
                        cm_valid_q    <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    cm_valid_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign cm_req_valid_o = cm_valid_q;
    assign cm_req_o       = req_q;
    assign ar_allow_o     = !ld_full;
    assign aw_allow_o     = !st_full;
    assign ld_cnt_o       = ld_cnt;
    assign st_cnt_o       = st_cnt;
    assign err_o          = ld_err || st_err;

endmodule
